// File: rtl/uart_tx_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_pkg
// Shared definitions for the UART transmit arbiter slice:
//   - arb_state_t : frame-slot FSM state encoding (IDLE, SEND, GAP)
//   - BIT_CYCLES_1200, FRAME_BITS_8N1G : default timing constants
//   - ptr_width() : width of a requester index for a given requester count
// ---------------------------------------------------------------------------
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } arb_state_t;

  // 1200 baud with a 16x oversampled clk_x derived by dividing CLK by 2*1302
  localparam int BIT_CYCLES_1200 = 41664;

  // start + 8 data + stop + 1 guard bit time
  localparam int FRAME_BITS_8N1G = 11;

  // A requester index needs at least one bit even when only two sources exist
  function automatic int ptr_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_if
// Bundles the requester-side handshake and the transmitter-side byte bus.
//   req      : per-requester level request
//   req_byte : requester i's byte in bits [8i+7:8i]
//   grant    : one-hot single-cycle acknowledge
//   tx_rdy   : to uat_top din_rdy
//   tx_byte  : to uat_top din_byte
//   busy     : frame slot in progress
// Modports: master = requester/consumer side, slave = the arbiter.
// ---------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 2
);

  logic [N_REQ-1:0]   req;
  logic [8*N_REQ-1:0] req_byte;
  logic [N_REQ-1:0]   grant;
  logic               tx_rdy;
  logic [7:0]         tx_byte;
  logic               busy;

  modport master (
    output req,
    output req_byte,
    input  grant,
    input  tx_rdy,
    input  tx_byte,
    input  busy
  );

  modport slave (
    input  req,
    input  req_byte,
    output grant,
    output tx_rdy,
    output tx_byte,
    output busy
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// uart_rr_pick
// Combinational circular priority picker.
//   req    : request vector
//   rr_ptr : index that has highest priority this time
//   valid  : at least one request is set
//   winner : index of the first set request scanning upward from rr_ptr
//   onehot : one-hot of winner, all zero when no request is set
// ---------------------------------------------------------------------------
module uart_rr_pick
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int PW    = ptr_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    rr_ptr,
  output logic             valid,
  output logic [PW-1:0]    winner,
  output logic [N_REQ-1:0] onehot
);

  // Visit indices rr_ptr, rr_ptr+1, ... modulo N_REQ and keep the first hit;
  // once valid is set later hits are ignored, which gives the rotation.
  always_comb begin
    int idx;
    valid  = 1'b0;
    winner = '0;
    onehot = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (!valid && req[idx]) begin
        valid  = 1'b1;
        winner = PW'(idx);
      end
    end
    if (valid) begin
      onehot[winner] = 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART transmitter between N_REQ byte sources. A round-robin
// winner's byte is latched and presented with tx_rdy for HOLD_BITS bit times
// so the slow clk_x domain can sample it, then the arbiter waits out the rest
// of a FRAME_BITS slot before granting again.
// Ports:
//   CLK   : system clock, rising edge
//   rst_p : asynchronous active-high reset
//   bus   : uart_tx_arbiter_if.slave (req/req_byte in, grant/tx_* /busy out)
// ---------------------------------------------------------------------------
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int BIT_CYCLES = BIT_CYCLES_1200,
  parameter int FRAME_BITS = FRAME_BITS_8N1G,
  parameter int HOLD_BITS  = 2,
  parameter int CW         = 19
) (
  input  logic              CLK,
  input  logic              rst_p,
  uart_tx_arbiter_if.slave  bus
);

  localparam int PW = ptr_width(N_REQ);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_BITS * BIT_CYCLES - 1);
  localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME_BITS * BIT_CYCLES - 1);

  arb_state_t       state;
  logic [CW-1:0]    cnt;
  logic [PW-1:0]    rr_ptr;
  logic [N_REQ-1:0] grant_q;
  logic             tx_rdy_q;
  logic [7:0]       tx_byte_q;
  logic             busy_q;

  logic             pick_valid;
  logic [PW-1:0]    pick_idx;
  logic [N_REQ-1:0] pick_onehot;
  logic [7:0]       pick_byte;

  uart_rr_pick #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_pick (
    .req    (bus.req),
    .rr_ptr (rr_ptr),
    .valid  (pick_valid),
    .winner (pick_idx),
    .onehot (pick_onehot)
  );

  // Select the winner's byte lane with a compare loop so the slice index
  // never has to be computed from a narrow pointer.
  always_comb begin
    pick_byte = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (PW'(k) == pick_idx) begin
        pick_byte = bus.req_byte[8*k +: 8];
      end
    end
  end

  // Frame-slot FSM. One counter spans the whole slot: it runs from 0 at the
  // grant through the hold window (SEND) and on into the guard time (GAP),
  // so the slot length is measured from the grant edge regardless of state.
  // grant is a single-cycle pulse; tx_byte is only rewritten on a grant.
  always_ff @(posedge CLK or posedge rst_p) begin
    if (rst_p) begin
      state     <= IDLE;
      cnt       <= '0;
      rr_ptr    <= '0;
      grant_q   <= '0;
      tx_rdy_q  <= 1'b0;
      tx_byte_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      grant_q <= '0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (pick_valid) begin
            state     <= SEND;
            tx_byte_q <= pick_byte;
            tx_rdy_q  <= 1'b1;
            grant_q   <= pick_onehot;
            busy_q    <= 1'b1;
            if (pick_idx == PW'(N_REQ - 1)) begin
              rr_ptr <= '0;
            end else begin
              rr_ptr <= pick_idx + 1'b1;
            end
          end else begin
            busy_q <= 1'b0;
          end
        end
        SEND: begin
          cnt <= cnt + 1'b1;
          if (cnt == HOLD_LAST) begin
            tx_rdy_q <= 1'b0;
            state    <= GAP;
          end
        end
        GAP: begin
          if (cnt == FRAME_LAST) begin
            cnt    <= '0;
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          cnt      <= '0;
          tx_rdy_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.grant   = grant_q;
  assign bus.tx_rdy  = tx_rdy_q;
  assign bus.tx_byte = tx_byte_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Self-checking bench for uart_tx_arbiter with N_REQ=2, BIT_CYCLES=4,
// FRAME_BITS=11, HOLD_BITS=2 (44-cycle slot, 8-cycle hold). The reference
// model reasons only in terms of "edges since the last grant" and a
// round-robin pointer.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int N    = 2;
  localparam int BC   = 4;
  localparam int FB   = 11;
  localparam int HB   = 2;
  localparam int SLOT = FB * BC;
  localparam int HOLD = HB * BC;

  logic CLK;
  logic rst_p;

  uart_tx_arbiter_if #(.N_REQ(N)) bus ();

  uart_tx_arbiter #(
    .N_REQ      (N),
    .BIT_CYCLES (BC),
    .FRAME_BITS (FB),
    .HOLD_BITS  (HB),
    .CW         (19)
  ) dut (
    .CLK   (CLK),
    .rst_p (rst_p),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  int         edge_n;
  int         last_g;
  int         ptr;
  logic [1:0] exp_grant;
  logic [7:0] exp_byte;
  logic       exp_rdy;
  logic       exp_busy;

  // Free-running system clock
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Single comparison point: counts and reports any disagreement
  task automatic check_output(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("[TB] FAIL %s t=%0t got=%h expected=%h", tag, $time, got, exp);
    end
  endtask

  task automatic check_all();
    check_output("grant",   {6'b0, bus.grant},  {6'b0, exp_grant});
    check_output("tx_rdy",  {7'b0, bus.tx_rdy}, {7'b0, exp_rdy});
    check_output("tx_byte", bus.tx_byte,        exp_byte);
    check_output("busy",    {7'b0, bus.busy},   {7'b0, exp_busy});
  endtask

  // Model state after reset: nothing granted yet, pointer at requester 0
  task automatic model_reset();
    edge_n    = 0;
    last_g    = -100000;
    ptr       = 0;
    exp_grant = '0;
    exp_byte  = '0;
    exp_rdy   = 1'b0;
    exp_busy  = 1'b0;
  endtask

  // A grant may happen once a full slot plus one idle edge has elapsed since
  // the previous grant; tx_rdy/busy are windows measured from that grant.
  task automatic model_edge();
    logic [1:0] r;
    bit         found;
    r     = bus.req;
    found = 1'b0;
    edge_n++;
    exp_grant = '0;
    if ((edge_n - last_g) >= SLOT + 1) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (ptr + k) % N;
        if (!found && r[j]) begin
          found        = 1'b1;
          exp_grant[j] = 1'b1;
          exp_byte     = bus.req_byte[8*j +: 8];
          ptr          = (j + 1) % N;
          last_g       = edge_n;
        end
      end
    end
    exp_rdy  = (edge_n - last_g) < HOLD;
    exp_busy = (edge_n - last_g) < SLOT;
  endtask

  // Drive req, take one edge, then check outputs 1 time unit later
  task automatic apply_stimulus(input logic [1:0] r);
    bus.req = r;
    @(posedge CLK);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic run(input logic [1:0] r, input int n);
    for (int i = 0; i < n; i++) apply_stimulus(r);
  endtask

  // Assert reset asynchronously, confirm outputs clear at once and stay
  // clear over a few edges, then release just after an edge.
  task automatic do_reset();
    rst_p = 1'b1;
    #1;
    model_reset();
    check_all();
    repeat (3) begin
      @(posedge CLK);
      #1;
      check_all();
    end
    rst_p = 1'b0;
  endtask

  initial begin
    logic [1:0] r;
    rst_p        = 1'b1;
    bus.req      = 2'b11;
    bus.req_byte = 16'h0000;

    $display("[TB] reset with all requests high");
    do_reset();

    $display("[TB] single request from 0");
    bus.req_byte[7:0] = 8'h41;
    apply_stimulus(2'b01);
    run(2'b00, 50);

    $display("[TB] both requesters held");
    do_reset();
    bus.req_byte = {8'hAA, 8'h55};
    run(2'b11, 4 * (SLOT + 1));
    run(2'b00, 2);

    $display("[TB] late request from 1 during GAP");
    do_reset();
    bus.req_byte = {8'h77, 8'h41};
    run(2'b01, 20);
    run(2'b11, 30);
    run(2'b00, 50);

    $display("[TB] reset mid-SEND");
    do_reset();
    bus.req_byte = {8'h99, 8'h41};
    run(2'b01, 3);
    bus.req = 2'b11;
    do_reset();
    run(2'b11, 5);
    run(2'b00, 50);

    $display("[TB] request 1 dropped after grant");
    do_reset();
    bus.req_byte = {8'h3C, 8'h00};
    apply_stimulus(2'b10);
    run(2'b00, 60);

    $display("[TB] random requesters");
    do_reset();
    r = 2'b00;
    for (int n = 0; n < 900; n++) begin
      for (int i = 0; i < N; i++) begin
        if (r[i]) begin
          if (exp_grant[i] && $urandom_range(0, 1) == 1) r[i] = 1'b0;
        end else if ($urandom_range(0, 5) == 0) begin
          bus.req_byte[8*i +: 8] = 8'($urandom);
          r[i] = 1'b1;
        end
      end
      apply_stimulus(r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
